instr_fetch: RTL and testbench

Instruction fetch front-end that drives the read port of the instruction ROM and delivers fetched instructions to the decode stage. It issues one word-aligned byte address per cycle and absorbs the ROM's fixed one-cycle registered read latency. A 2-entry output queue lets decode stall without losing in-flight words. It handles PC redirects from branches and jumps by flushing queued and in-flight fetches.

---
 rtl/instr_fetch.sv | 187 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch front-end. It drives the read port of an instruction ROM
// that has a one-cycle registered read latency, and it delivers
// (pc, instruction) pairs to decode through a 2-entry queue. When a redirect
// arrives, the queue and the in-flight fetch are flushed and fetching
// restarts at the redirect PC in the same cycle.
//
// Optional feature (compile-time macro INSTR_FETCH_PERF_EN):
//   Adds o_fetch_cnt, a wrapping 32-bit count of decode transfers.
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous, active-high reset
//   o_i_addr       out  14  ROM byte address, bits [1:0] always 0
//   i_rdata        in   32  ROM data, valid one cycle after its address
//   o_valid        out  1   queue head holds an instruction
//   o_pc           out  32  PC of the queue head
//   o_instr        out  32  instruction word of the queue head
//   i_ready        in   1   decode takes the head when o_valid is high
//   i_redirect     in   1   one-cycle fetch restart request
//   i_redirect_pc  in   32  restart PC, bits [1:0] ignored
//   o_fetch_cnt    out  32  transfer count (INSTR_FETCH_PERF_EN only)
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [13:0] o_i_addr,
    input  logic [31:0] i_rdata,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [31:0] o_fetch_cnt
`endif
);

    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

    // Fetch state
    logic [31:0] pc_r;
    logic        infl_v_r;
    logic [31:0] infl_pc_r;
    logic [13:0] addr_r;

    // Queue storage: the head entry drives the outputs directly
    logic [31:0] head_pc_r;
    logic [31:0] head_instr_r;
    logic [31:0] tail_pc_r;
    logic [31:0] tail_instr_r;
    logic [1:0]  count_r;

    // Per-cycle control
    logic        xfer_s;
    logic        issue_s;
    logic [31:0] issue_pc_s;
    logic [31:0] redir_pc_s;
    logic        push_s;
    logic        pop_s;
    logic [2:0]  occupancy_s;

    assign o_valid    = (count_r != 2'd0);
    assign o_pc       = head_pc_r;
    assign o_instr    = head_instr_r;
    assign xfer_s     = o_valid & i_ready;
    assign redir_pc_s = i_redirect_pc & PC_ALIGN_MASK;

    // A redirect discards the returning word and any pop; the flushed queue
    // must not be touched by either.
    assign push_s = infl_v_r & ~i_redirect;
    assign pop_s  = xfer_s & ~i_redirect;

    // Words already buffered plus the word still coming back from the ROM.
    assign occupancy_s = {1'b0, count_r} + {2'b00, infl_v_r};

    // Issue decision and ROM address: new address when issuing, else hold.
    always_comb begin
        issue_s    = 1'b0;
        issue_pc_s = pc_r;
        if (rst) begin
            issue_s    = 1'b0;
            issue_pc_s = pc_r;
        end else if (i_redirect) begin
            issue_s    = 1'b1;
            issue_pc_s = redir_pc_s;
        end else if ((occupancy_s < 3'd2) || xfer_s) begin
            // A pop this cycle frees the slot the new word will need.
            issue_s    = 1'b1;
            issue_pc_s = pc_r;
        end else begin
            issue_s    = 1'b0;
            issue_pc_s = pc_r;
        end

        if (issue_s) begin
            o_i_addr = issue_pc_s[13:0];
        end else begin
            o_i_addr = addr_r;
        end
    end

    // Fetch pointer, in-flight tracking and held ROM address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= RESET_PC_ALIGNED;
            infl_v_r  <= 1'b0;
            infl_pc_r <= 32'h0000_0000;
            addr_r    <= 14'h0000;
        end else begin
            addr_r   <= o_i_addr;
            infl_v_r <= issue_s;
            if (issue_s) begin
                infl_pc_r <= issue_pc_s;
                pc_r      <= issue_pc_s + 32'd4;
            end
        end
    end

    // Two-entry queue: shifts tail into head on pop, appends on push.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_pc_r    <= 32'h0000_0000;
            head_instr_r <= 32'h0000_0000;
            tail_pc_r    <= 32'h0000_0000;
            tail_instr_r <= 32'h0000_0000;
            count_r      <= 2'd0;
        end else if (i_redirect) begin
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b11: begin
                    if (count_r == 2'd2) begin
                        head_pc_r    <= tail_pc_r;
                        head_instr_r <= tail_instr_r;
                        tail_pc_r    <= infl_pc_r;
                        tail_instr_r <= i_rdata;
                    end else begin
                        head_pc_r    <= infl_pc_r;
                        head_instr_r <= i_rdata;
                    end
                end
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_pc_r    <= infl_pc_r;
                        head_instr_r <= i_rdata;
                    end else begin
                        tail_pc_r    <= infl_pc_r;
                        tail_instr_r <= i_rdata;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_pc_r    <= tail_pc_r;
                    head_instr_r <= tail_instr_r;
                    count_r      <= count_r - 2'd1;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] fetch_cnt_r;

    assign o_fetch_cnt = fetch_cnt_r;

    // Transfer counter; a transfer in a redirect cycle still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_r <= 32'h0000_0000;
        end else if (xfer_s) begin
            fetch_cnt_r <= fetch_cnt_r + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] o_i_addr;
    logic [31:0] i_rdata;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        i_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] o_fetch_cnt;
`endif

    int total = 0;
    int bad   = 0;

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .o_i_addr      (o_i_addr),
        .i_rdata       (i_rdata),
        .o_valid       (o_valid),
        .o_pc          (o_pc),
        .o_instr       (o_instr),
        .i_ready       (i_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .o_fetch_cnt   (o_fetch_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ROM model: five words, everything else reads 0, one-cycle registered read.
    logic [31:0] rom [0:4];
    initial begin
        rom[0] = 32'h2100_6093;
        rom[1] = 32'h0210_e113;
        rom[2] = 32'h0011_1193;
        rom[3] = 32'h5681_f213;
        rom[4] = 32'h68a0_6293;
    end
    always @(posedge clk) begin
        if (o_i_addr[13:2] < 12'd5) i_rdata <= rom[o_i_addr[4:2]];
        else                        i_rdata <= 32'h0000_0000;
    end

    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        chk_ctl;
        logic        exp_valid;
        logic [13:0] exp_addr;
        logic        chk_data;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [0:63];
    int   n_vec = 0;

    task automatic add(input logic r, input logic rd, input logic rdr, input logic [31:0] rpc,
                       input logic cc, input logic ev, input logic [13:0] ea,
                       input logic cd, input logic [31:0] ep, input logic [31:0] ei);
        vecs[n_vec] = '{r, rd, rdr, rpc, cc, ev, ea, cd, ep, ei};
        n_vec++;
    endtask

    // Reset prefix: first cycle unchecked, second expects the reset state.
    task automatic add_reset();
        add(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 14'h0, 1'b0, 32'd0, 32'd0);
        add(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 14'h0, 1'b0, 32'd0, 32'd0);
    endtask

    // Plain streaming row with i_ready=1 and no redirect.
    task automatic add_run(input logic ev, input logic [13:0] ea, input logic [31:0] ep, input logic [31:0] ei);
        add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, ev, ea, ev, ep, ei);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic rdr, input logic [31:0] rpc);
        @(negedge clk);
        rst           = r;
        i_ready       = rd;
        i_redirect    = rdr;
        i_redirect_pc = rpc;
        #1;
    endtask

    task automatic chk_ctl(input string nm, input int idx, input logic ev, input logic [13:0] ea);
        chk({nm, "_valid"}, idx, {31'd0, o_valid}, {31'd0, ev});
        chk({nm, "_addr"}, idx, {18'd0, o_i_addr}, {18'd0, ea});
    endtask

    task automatic chk_head(input string nm, input int idx, input logic [31:0] ep, input logic [31:0] ei);
        chk({nm, "_pc"}, idx, o_pc, ep);
        chk({nm, "_instr"}, idx, o_instr, ei);
    endtask

    logic [31:0] exp_pcs   [0:3];
    logic [31:0] exp_words [0:3];

    initial begin
        rst = 1'b1; i_ready = 1'b1; i_redirect = 1'b0; i_redirect_pc = 32'd0;

        // Streaming from reset: first valid in cycle 2, PC 0x14 reads 0.
        add_reset();
        add_run(1'b0, 14'h00, 32'h0, 32'h0);
        add_run(1'b0, 14'h04, 32'h0, 32'h0);
        add_run(1'b1, 14'h08, 32'h00, 32'h2100_6093);
        add_run(1'b1, 14'h0C, 32'h04, 32'h0210_e113);
        add_run(1'b1, 14'h10, 32'h08, 32'h0011_1193);
        add_run(1'b1, 14'h14, 32'h0C, 32'h5681_f213);
        add_run(1'b1, 14'h18, 32'h10, 32'h68a0_6293);
        add_run(1'b1, 14'h1C, 32'h14, 32'h0000_0000);

        // Redirect to 0x10 in cycle 4: the PC 8 transfer still completes,
        // cycle 5 shows nothing, 0x10 is at the head in cycle 6.
        add_reset();
        add_run(1'b0, 14'h00, 32'h0, 32'h0);
        add_run(1'b0, 14'h04, 32'h0, 32'h0);
        add_run(1'b1, 14'h08, 32'h00, 32'h2100_6093);
        add_run(1'b1, 14'h0C, 32'h04, 32'h0210_e113);
        add(1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 14'h10, 1'b1, 32'h08, 32'h0011_1193);
        add_run(1'b0, 14'h14, 32'h0, 32'h0);
        add_run(1'b1, 14'h18, 32'h10, 32'h68a0_6293);
        add_run(1'b1, 14'h1C, 32'h14, 32'h0000_0000);

        // Back-to-back redirects 0x4 then 0xC: only the 0xC stream appears.
        add_reset();
        add_run(1'b0, 14'h00, 32'h0, 32'h0);
        add_run(1'b0, 14'h04, 32'h0, 32'h0);
        add(1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 1'b1, 14'h04, 1'b1, 32'h00, 32'h2100_6093);
        add(1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 1'b0, 14'h0C, 1'b0, 32'h0, 32'h0);
        add_run(1'b0, 14'h10, 32'h0, 32'h0);
        add_run(1'b1, 14'h14, 32'h0C, 32'h5681_f213);
        add_run(1'b1, 14'h18, 32'h10, 32'h68a0_6293);

        // Unaligned redirect PC 0x7 is fetched as 0x4.
        add_reset();
        add_run(1'b0, 14'h00, 32'h0, 32'h0);
        add_run(1'b0, 14'h04, 32'h0, 32'h0);
        add(1'b0, 1'b1, 1'b1, 32'h07, 1'b1, 1'b1, 14'h04, 1'b1, 32'h00, 32'h2100_6093);
        add_run(1'b0, 14'h08, 32'h0, 32'h0);
        add_run(1'b1, 14'h0C, 32'h04, 32'h0210_e113);

        for (int i = 0; i < n_vec; i++) begin
            drive(vecs[i].rst, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            if (vecs[i].chk_ctl) chk_ctl("vec", i, vecs[i].exp_valid, vecs[i].exp_addr);
            if (vecs[i].chk_data) chk_head("vec", i, vecs[i].exp_pc, vecs[i].exp_instr);
        end

        // Stall from cycle 2 for 5 cycles: queue holds PCs 0 and 4, issue
        // stops with address 0x4 held; release issues 0x8 in the same cycle.
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        chk_ctl("stall_c0", 0, 1'b0, 14'h00);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        chk_ctl("stall_c1", 1, 1'b0, 14'h04);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            chk_ctl("stall_hold", i, 1'b1, 14'h04);
            chk_head("stall_hold", i, 32'h00, 32'h2100_6093);
        end
        exp_pcs[0] = 32'h00; exp_words[0] = 32'h2100_6093;
        exp_pcs[1] = 32'h04; exp_words[1] = 32'h0210_e113;
        exp_pcs[2] = 32'h08; exp_words[2] = 32'h0011_1193;
        exp_pcs[3] = 32'h0C; exp_words[3] = 32'h5681_f213;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd0);
            chk_ctl("release", i, 1'b1, 14'h08 + 14'(4 * i));
            chk_head("release", i, exp_pcs[i], exp_words[i]);
        end

        // Reset with a full stalled queue, then restart from RESET_PC.
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk_ctl("full_before_rst", 0, 1'b1, 14'h04);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        chk_ctl("after_rst_c0", 0, 1'b0, 14'h00);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        chk_ctl("after_rst_c1", 1, 1'b0, 14'h04);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        chk_ctl("after_rst_c2", 2, 1'b1, 14'h08);
        chk_head("after_rst_c2", 2, 32'h00, 32'h2100_6093);

`ifdef INSTR_FETCH_PERF_EN
        // Five accepted transfers, then a wrap from FFFFFFFF to 0.
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        chk("cnt_reset", 0, o_fetch_cnt, 32'd0);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("cnt_five", 0, o_fetch_cnt, 32'd5);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        dut.fetch_cnt_r = 32'hFFFF_FFFF;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("cnt_wrap", 0, o_fetch_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
